sensor_conditioner: RTL and testbench

SENSOR_CONDITIONER -- requirements
Module: sensor_conditioner

---
 rtl/sensor_conditioner_pkg.sv | 26 ++
 rtl/sensor_conditioner_if.sv | 26 ++
 rtl/sensor_conditioner_deb_channel.sv | 64 ++++++
 rtl/sensor_conditioner.sv | 117 +++++++++++
 tb/tb_sensor_conditioner.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/sensor_conditioner_pkg.sv
// Shared defaults, channel indices and sizing helper for the sensor conditioner.
package sensor_conditioner_pkg;

  localparam int unsigned CLK_DIV_DEF    = 50000;
  localparam int unsigned DEB_COUNT_DEF  = 20;
  localparam int unsigned AUTO_TICKS_DEF = 3000;

  // Channel indices into the filtered-input vector.
  localparam int unsigned IdxH   = 0;
  localparam int unsigned IdxM   = 1;
  localparam int unsigned IdxL   = 2;
  localparam int unsigned IdxUa  = 3;
  localparam int unsigned IdxUs  = 4;
  localparam int unsigned IdxT   = 5;
  localparam int unsigned IdxBtn = 6;

  // Level channels feed chg; the button channel only drives the view toggle.
  localparam int unsigned NumLvl = 6;
  localparam int unsigned NumCh  = 7;

  // Width of a counter holding 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sensor_conditioner_if.sv
// Raw probe/switch inputs and conditioned outputs of the sensor conditioner.
interface sensor_conditioner_if;

  logic h_raw, m_raw, l_raw;
  logic ua_raw, us_raw, t_raw;
  logic view_btn_raw;
  logic auto_en;

  logic H, M, L, Ua, Us, T;
  logic S;
  logic valid;
  logic chg;

  // Environment side: drives raw inputs, consumes conditioned outputs.
  modport master (
    output h_raw, m_raw, l_raw, ua_raw, us_raw, t_raw, view_btn_raw, auto_en,
    input  H, M, L, Ua, Us, T, S, valid, chg
  );

  // Conditioner side.
  modport slave (
    input  h_raw, m_raw, l_raw, ua_raw, us_raw, t_raw, view_btn_raw, auto_en,
    output H, M, L, Ua, Us, T, S, valid, chg
  );

endinterface

// File: rtl/sensor_conditioner_deb_channel.sv
// One debounced input: 2-flop synchronizer, tick-driven run counter, output flop.
module deb_channel
  import sensor_conditioner_pkg::*;
#(
  parameter int unsigned DEB_COUNT = DEB_COUNT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic raw,
  output logic level,
  // High in the cycle before level takes a new value.
  output logic flip
);

  localparam int unsigned CntW = cnt_width(DEB_COUNT);

  logic            sync1_q, sync2_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            level_q, level_d;

  // Two-flop synchronizer ahead of all filtering.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  // Count consecutive differing ticks; accept the new level on the last one.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    flip    = 1'b0;
    if (tick) begin
      if (sync2_q == level_q) begin
        cnt_d = '0;
      end else if (cnt_q == CntW'(DEB_COUNT - 1)) begin
        level_d = sync2_q;
        cnt_d   = '0;
        flip    = 1'b1;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  // Counter and output state.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/sensor_conditioner.sv
// Sensor conditioner: shared prescaler, seven debounced channels, valid/chg flags
// and the tank/irrigation display view selector.
module sensor_conditioner
  import sensor_conditioner_pkg::*;
#(
  parameter int unsigned CLK_DIV    = CLK_DIV_DEF,
  parameter int unsigned DEB_COUNT  = DEB_COUNT_DEF,
  parameter int unsigned AUTO_TICKS = AUTO_TICKS_DEF
) (
  input logic                 clk,
  input logic                 reset,
  sensor_conditioner_if.slave bus
);

  localparam int unsigned PresW = cnt_width(CLK_DIV);
  localparam int unsigned ValW  = cnt_width(DEB_COUNT);
  localparam int unsigned AutoW = cnt_width(AUTO_TICKS);

  logic [NumCh-1:0] raw, level, flip;
  logic             tick;

  logic [PresW-1:0] presc_q, presc_d;
  logic [ValW-1:0]  val_cnt_q, val_cnt_d;
  logic             valid_q, valid_d;
  logic             chg_q, chg_d;
  logic [AutoW-1:0] auto_q, auto_d;
  logic             s_q, s_d;
  logic             btn_rise, auto_exp;

  assign raw[IdxH]   = bus.h_raw;
  assign raw[IdxM]   = bus.m_raw;
  assign raw[IdxL]   = bus.l_raw;
  assign raw[IdxUa]  = bus.ua_raw;
  assign raw[IdxUs]  = bus.us_raw;
  assign raw[IdxT]   = bus.t_raw;
  assign raw[IdxBtn] = bus.view_btn_raw;

  for (genvar ch = 0; ch < NumCh; ch++) begin : g_ch
    deb_channel #(
      .DEB_COUNT(DEB_COUNT)
    ) u_deb (
      .clk  (clk),
      .reset(reset),
      .tick (tick),
      .raw  (raw[ch]),
      .level(level[ch]),
      .flip (flip[ch])
    );
  end

  // Prescaler wraps after CLK_DIV cycles, ticking on its last count.
  always_comb begin
    tick    = (presc_q == PresW'(CLK_DIV - 1));
    presc_d = tick ? '0 : presc_q + PresW'(1);
  end

  // valid rises on the DEB_COUNT-th tick after reset and then sticks.
  always_comb begin
    val_cnt_d = val_cnt_q;
    valid_d   = valid_q;
    if (tick && !valid_q) begin
      if (val_cnt_q == ValW'(DEB_COUNT - 1)) begin
        valid_d = 1'b1;
      end else begin
        val_cnt_d = val_cnt_q + ValW'(1);
      end
    end
  end

  // chg is registered alongside the levels so it lines up with the new value.
  always_comb begin
    chg_d = |flip[NumLvl-1:0];
  end

  // View select: button rising edge or auto expiry toggles once; either clears the counter.
  always_comb begin
    btn_rise = flip[IdxBtn] & ~level[IdxBtn];
    auto_exp = bus.auto_en & tick & (auto_q == AutoW'(AUTO_TICKS - 1));
    s_d      = s_q ^ (btn_rise | auto_exp);
    auto_d   = auto_q;
    if (!bus.auto_en || btn_rise) begin
      auto_d = '0;
    end else if (tick) begin
      auto_d = auto_exp ? '0 : auto_q + AutoW'(1);
    end
  end

  // Top-level state.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q   <= '0;
      val_cnt_q <= '0;
      valid_q   <= 1'b0;
      chg_q     <= 1'b0;
      auto_q    <= '0;
      s_q       <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      val_cnt_q <= val_cnt_d;
      valid_q   <= valid_d;
      chg_q     <= chg_d;
      auto_q    <= auto_d;
      s_q       <= s_d;
    end
  end

  assign bus.H     = level[IdxH];
  assign bus.M     = level[IdxM];
  assign bus.L     = level[IdxL];
  assign bus.Ua    = level[IdxUa];
  assign bus.Us    = level[IdxUs];
  assign bus.T     = level[IdxT];
  assign bus.S     = s_q;
  assign bus.valid = valid_q;
  assign bus.chg   = chg_q;

endmodule

// File: tb/tb_sensor_conditioner.sv
// Self-checking bench for sensor_conditioner with a behavioural reference model.
module tb_sensor_conditioner;
  import sensor_conditioner_pkg::*;

  localparam int unsigned CD = 4;
  localparam int unsigned DB = 3;
  localparam int unsigned AT = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] raw_in = '0;
  logic       auto_in = 1'b0;

  always #5 clk = ~clk;

  sensor_conditioner_if bus ();

  assign bus.h_raw        = raw_in[IdxH];
  assign bus.m_raw        = raw_in[IdxM];
  assign bus.l_raw        = raw_in[IdxL];
  assign bus.ua_raw       = raw_in[IdxUa];
  assign bus.us_raw       = raw_in[IdxUs];
  assign bus.t_raw        = raw_in[IdxT];
  assign bus.view_btn_raw = raw_in[IdxBtn];
  assign bus.auto_en      = auto_in;

  sensor_conditioner #(
    .CLK_DIV   (CD),
    .DEB_COUNT (DB),
    .AUTO_TICKS(AT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int passed = 0;
  int total  = 0;

  // Reference model: a value is accepted once the last DB tick samples all
  // disagree with the current output.
  bit [6:0] pipe1, pipe2, m_out;
  bit       hist[7][$];
  int       cyc, ticks, acnt;
  bit       m_valid, m_chg, m_s;

  // Observation helpers for directed phases.
  int       chg_seen, s_toggles, steps;
  logic     s_prev;

  task automatic model_edge();
    bit       tk, rise, expd, all_diff;
    bit [6:0] prev;
    if (reset) begin
      pipe1 = '0; pipe2 = '0; m_out = '0;
      for (int c = 0; c < 7; c++) hist[c].delete();
      cyc = 0; ticks = 0; acnt = 0;
      m_valid = 0; m_chg = 0; m_s = 0;
      return;
    end
    tk   = ((cyc % CD) == CD - 1);
    prev = m_out;
    if (tk) begin
      for (int c = 0; c < 7; c++) begin
        hist[c].push_back(pipe2[c]);
        if (hist[c].size() > DB) void'(hist[c].pop_front());
        if (hist[c].size() == DB) begin
          all_diff = 1;
          for (int i = 0; i < hist[c].size(); i++)
            if (hist[c][i] == m_out[c]) all_diff = 0;
          if (all_diff) m_out[c] = ~m_out[c];
        end
      end
      ticks++;
    end
    m_chg   = (prev[5:0] != m_out[5:0]);
    m_valid = (ticks >= DB);
    rise    = !prev[IdxBtn] && m_out[IdxBtn];
    expd    = auto_in && tk && (acnt == AT - 1);
    if (rise || expd) m_s = ~m_s;
    if (!auto_in || rise) acnt = 0;
    else if (tk) acnt = expd ? 0 : acnt + 1;
    pipe2 = pipe1;
    pipe1 = raw_in;
    cyc++;
  endtask

  task automatic check(input string tag, input logic obs, input bit exp);
    total++;
    assert (obs === logic'(exp)) passed++;
    else begin
      $display("FAIL %s at %0t: observed %b expected %b", tag, $time, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs == exp) passed++;
    else begin
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("H", bus.H, m_out[IdxH]);
    check("M", bus.M, m_out[IdxM]);
    check("L", bus.L, m_out[IdxL]);
    check("Ua", bus.Ua, m_out[IdxUa]);
    check("Us", bus.Us, m_out[IdxUs]);
    check("T", bus.T, m_out[IdxT]);
    check("S", bus.S, m_s);
    check("valid", bus.valid, m_valid);
    check("chg", bus.chg, m_chg);
    chg_seen += (bus.chg === 1'b1) ? 1 : 0;
    if (bus.S !== s_prev) s_toggles++;
    s_prev = bus.S;
    steps++;
  endtask

  task automatic clear_obs();
    chg_seen = 0; s_toggles = 0; steps = 0; s_prev = bus.S;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) step();
    reset = 1'b0;
    clear_obs();
  endtask

  initial begin
    int first_rise;

    // Reset state.
    raw_in = '0; auto_in = 0;
    do_reset(3);
    check("rst_S", bus.S, 1'b0);
    check("rst_valid", bus.valid, 1'b0);

    // h_raw held: sync reaches the channel at edge 2, ticks at edges 4, 8, 12.
    raw_in[IdxH] = 1;
    first_rise = -1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (first_rise < 0 && bus.H === 1'b1) first_rise = steps;
    end
    check_int("h_rise_step", first_rise, 12);
    check_int("h_chg_pulses", chg_seen, 1);
    check("valid_after_3_ticks", bus.valid, 1'b1);

    // m_raw glitch of 8 cycles must be filtered out.
    clear_obs();
    raw_in[IdxM] = 1;
    for (int i = 0; i < 8; i++) step();
    raw_in[IdxM] = 0;
    for (int i = 0; i < 20; i++) step();
    check("m_glitch", bus.M, 1'b0);
    check_int("m_glitch_chg", chg_seen, 0);

    // Button held 20 cycles with auto off: one toggle, S stays 1 after release.
    clear_obs();
    raw_in[IdxBtn] = 1;
    for (int i = 0; i < 20; i++) step();
    raw_in[IdxBtn] = 0;
    for (int i = 0; i < 24; i++) step();
    check_int("btn_toggles", s_toggles, 1);
    check("btn_S", bus.S, 1'b1);

    // Auto toggling every 5 ticks.
    raw_in = '0;
    do_reset(2);
    auto_in = 1;
    for (int i = 0; i < 60; i++) step();
    check_int("auto_toggles", s_toggles, 3);

    // Button acceptance lands on edge 20, same as the auto expiry.
    auto_in = 0;
    do_reset(2);
    auto_in = 1;
    for (int i = 0; i < 9; i++) step();
    raw_in[IdxBtn] = 1;
    for (int i = 0; i < 21; i++) step();
    check_int("coincide_toggles", s_toggles, 1);
    check("coincide_S", bus.S, 1'b1);
    for (int i = 0; i < 15; i++) step();
    check_int("coincide_next_expiry", s_toggles, 2);

    // Reset one tick into a t_raw debounce discards the partial count.
    raw_in = '0; auto_in = 0;
    do_reset(2);
    raw_in[IdxT] = 1;
    for (int i = 0; i < 5; i++) step();
    reset = 1'b1;
    step();
    check("mid_rst_T", bus.T, 1'b0);
    check("mid_rst_valid", bus.valid, 1'b0);
    step();
    reset = 1'b0;
    clear_obs();
    first_rise = -1;
    for (int i = 0; i < 16; i++) begin
      step();
      if (first_rise < 0 && bus.T === 1'b1) first_rise = steps;
    end
    check_int("t_rise_after_rst", first_rise, 12);

    // Randomized slowly-varying inputs with occasional auto_en flips and resets.
    raw_in = '0;
    do_reset(2);
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < 7; c++)
        if ($urandom_range(11) == 0) raw_in[c] = ~raw_in[c];
      if ($urandom_range(59) == 0) auto_in = ~auto_in;
      reset = ($urandom_range(399) == 0);
      step();
    end
    reset = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
